pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (e.g. MEM/WB).
- Carries a generic payload between pipeline stages: data words, destination register and control bits.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush, and bubble gating of control bits.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-instance widths.

---
 rtl/pipe_stage_reg.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register with valid/ready
// handshake, 2-entry skid buffer, synchronous flush and bubble gating.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush, empties the stage
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    NUM_DATA words, word k at [k*DATA_W +: DATA_W]
//   in_rd      upstream destination register
//   in_ctrl    upstream control bits
//   out_valid  head entry valid
//   out_ready  downstream accepts (low = stall)
//   out_data   head-entry data words (not gated)
//   out_rd     head-entry destination, 0 when out_valid=0
//   out_ctrl   head-entry control, 0 when out_valid=0
//   occupancy  entries held: 0, 1 or 2
//
// Optional build macro PIPE_STAGE_PERF_EN adds saturating counters:
//   stall_cnt  cycles with out_valid=1 and out_ready=0
//   bubble_cnt cycles with out_valid=0 (outside reset)

module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int RD_W     = 5,
    parameter int CTRL_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]            in_rd,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]            out_rd,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt
`endif
);

    localparam int P = NUM_DATA * DATA_W;

    // Encoding equals the entry count so occupancy is the state itself.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;

    logic [P-1:0]      main_data_q, main_data_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              main_valid_q, main_valid_d;

    logic [P-1:0]      skid_data_q, skid_data_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              skid_valid_q, skid_valid_d;

    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_rd_d    = main_rd_q;
        main_ctrl_d  = main_ctrl_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // Data words are left stale; gating hides rd/ctrl.
            state_d      = S_EMPTY;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_data_d  = in_data;
                        main_rd_d    = in_rd;
                        main_ctrl_d  = in_ctrl;
                        main_valid_d = 1'b1;
                        state_d      = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_rd_d   = in_rd;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        // Head is stalled: park the newcomer behind it.
                        skid_data_d  = in_data;
                        skid_rd_d    = in_rd;
                        skid_ctrl_d  = in_ctrl;
                        skid_valid_d = 1'b1;
                        state_d      = S_FULL;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                        state_d      = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_data_d  = skid_data_q;
                        main_rd_d    = skid_rd_q;
                        main_ctrl_d  = skid_ctrl_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_ONE;
                    end
                end
                default: begin
                    state_d      = S_EMPTY;
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end

        // Registered ready: only looks at our own next state.
        in_ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            in_ready_q   <= 1'b1;
            main_data_q  <= '0;
            main_rd_q    <= '0;
            main_ctrl_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            skid_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            main_rd_q    <= main_rd_d;
            main_ctrl_q  <= main_ctrl_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    // A bubble must never present a live RegWrite or destination.
    assign out_rd    = main_valid_q ? main_rd_q : '0;
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!main_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Inputs driven and outputs sampled on the falling clock edge.

module tb_pipe_stage_reg;

    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 3;
    localparam int RD_W     = 5;
    localparam int CTRL_W   = 3;
    localparam int P        = NUM_DATA * DATA_W;
    localparam int E        = P + RD_W + CTRL_W;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [P-1:0]      in_data;
    logic [RD_W-1:0]   in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [P-1:0]      out_data;
    logic [RD_W-1:0]   out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    logic [E-1:0] sb[$];
    logic [E-1:0] exp_e;
    logic [E-1:0] got_e;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .NUM_DATA (NUM_DATA),
        .RD_W     (RD_W),
        .CTRL_W   (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    assign got_e = {out_data, out_rd, out_ctrl};

    function automatic logic [E-1:0] mk(input int t);
        logic [P-1:0]      d;
        logic [RD_W-1:0]   r;
        logic [CTRL_W-1:0] c;
        d = {32'h300 + t, 32'h200 + t, 32'h100 + t};
        r = RD_W'(t);
        c = CTRL_W'((t % 7) + 1);
        return {d, r, c};
    endfunction

    task automatic drive(input int t);
        logic [E-1:0] e;
        e = mk(t);
        in_valid = 1'b1;
        {in_data, in_rd, in_ctrl} = e;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_rd    = '0;
        in_ctrl  = '0;
    endtask

    task automatic drain();
        idle_in();
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        idle_in();
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            fails++;
            $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
        end
        checks++;
        if (out_ctrl !== '0 || out_rd !== '0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_payload ctrl=%b rd=%0d data=%h exp=0",
                     out_ctrl, out_rd, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {32'h33, 32'h22, 32'h11};
        in_rd     = 5'd7;
        in_ctrl   = 3'b101;
        @(negedge clk);
        idle_in();
        checks++;
        if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL single_valid got v=%b occ=%0d exp v=1 occ=1",
                     out_valid, occupancy);
        end
        checks++;
        if (out_rd !== 5'd7 || out_ctrl !== 3'b101) begin
            fails++;
            $display("FAIL single_rd_ctrl got rd=%0d ctrl=%b exp rd=7 ctrl=101",
                     out_rd, out_ctrl);
        end
        checks++;
        if (out_data !== {32'h33, 32'h22, 32'h11}) begin
            fails++;
            $display("FAIL single_data got=%h exp=%h", out_data,
                     {32'h33, 32'h22, 32'h11});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_rd !== '0) begin
            fails++;
            $display("FAIL single_bubble got v=%b ctrl=%b rd=%0d exp 0",
                     out_valid, out_ctrl, out_rd);
        end
    endtask

    task automatic test_streaming();
        int outs = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== ((c >= 1) && (c <= 8))) begin
                fails++;
                $display("FAIL stream_valid cyc=%0d got=%b", c, out_valid);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra got=%h exp=none", got_e);
                end else begin
                    exp_e = sb.pop_front();
                    outs++;
                    if (got_e !== exp_e) begin
                        fails++;
                        $display("FAIL stream_payload got=%h exp=%h",
                                 got_e, exp_e);
                    end
                end
            end
            if (c < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_in_ready cyc=%0d got=%b exp=1",
                             c, in_ready);
                end
                drive(c + 1);
                sb.push_back(mk(c + 1));
            end else begin
                idle_in();
            end
            @(negedge clk);
        end
        checks++;
        if (outs != 8 || sb.size() != 0) begin
            fails++;
            $display("FAIL stream_count got=%0d left=%0d exp=8 left=0",
                     outs, sb.size());
        end
    endtask

    task automatic test_back_pressure();
        bit pending;
        int outs = 0;
        int cyc  = 0;
        out_ready = 1'b0;
        drive(1);
        sb.push_back(mk(1));
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_one got occ=%0d rdy=%b exp occ=1 rdy=1",
                     occupancy, in_ready);
        end
        drive(2);
        sb.push_back(mk(2));
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0",
                     occupancy, in_ready);
        end
        drive(3);
        pending = 1'b1;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2 || out_valid !== 1'b1 || got_e !== mk(1)) begin
            fails++;
            $display("FAIL bp_hold got occ=%0d v=%b out=%h exp occ=2 v=1 out=%h",
                     occupancy, out_valid, got_e, mk(1));
        end
        out_ready = 1'b1;
        while (cyc < 10 && (sb.size() != 0 || pending || out_valid)) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra got=%h exp=none", got_e);
                end else begin
                    exp_e = sb.pop_front();
                    outs++;
                    if (got_e !== exp_e) begin
                        fails++;
                        $display("FAIL bp_order got=%h exp=%h", got_e, exp_e);
                    end
                end
            end
            if (pending && in_ready === 1'b1) begin
                sb.push_back(mk(3));
                pending = 1'b0;
            end else if (!pending) begin
                idle_in();
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (outs != 3 || sb.size() != 0 || pending) begin
            fails++;
            $display("FAIL bp_count got=%0d left=%0d exp=3 left=0",
                     outs, sb.size());
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        drive(4);
        @(negedge clk);
        drive(5);
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL flush_setup occ got=%0d exp=2", occupancy);
        end
        flush = 1'b1;
        drive(9);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state got occ=%0d v=%b rdy=%b exp 0/0/1",
                     occupancy, out_valid, in_ready);
        end
        checks++;
        if (out_ctrl !== '0 || out_rd !== '0) begin
            fails++;
            $display("FAIL flush_gating got ctrl=%b rd=%0d exp 0",
                     out_ctrl, out_rd);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_ghost cyc=%0d got out=%h exp no output",
                         c, got_e);
            end
        end
        // Flush in ONE with a concurrent accepted input drops it too.
        drive(10);
        @(negedge clk);
        flush = 1'b1;
        drive(11);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== '0) begin
            fails++;
            $display("FAIL flush_one got v=%b occ=%0d ctrl=%b exp 0",
                     out_valid, occupancy, out_ctrl);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(12);
        @(negedge clk);
        idle_in();
        checks++;
        if (occupancy !== 2'd1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_setup got occ=%0d v=%b exp occ=1 v=1",
                     occupancy, out_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL areset_now got v=%b rdy=%b occ=%0d exp 0/1/0",
                     out_valid, in_ready, occupancy);
        end
        checks++;
        if (out_ctrl !== '0 || out_rd !== '0 || out_data !== '0) begin
            fails++;
            $display("FAIL areset_payload got ctrl=%b rd=%0d data=%h exp 0",
                     out_ctrl, out_rd, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        logic [31:0] s0;
        logic [31:0] b0;
        out_ready = 1'b0;
        drive(13);
        @(negedge clk);
        idle_in();
        s0 = stall_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (stall_cnt - s0 !== 32'd5) begin
            fails++;
            $display("FAIL perf_stall got=%0d exp=5", stall_cnt - s0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        b0 = bubble_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (bubble_cnt - b0 < 32'd3) begin
            fails++;
            $display("FAIL perf_bubble got=%0d exp>=3", bubble_cnt - b0);
        end
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        out_ready = 1'b0;
        drive(14);
        @(negedge clk);
        idle_in();
        repeat (3) @(negedge clk);
        checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL perf_saturate got=%h exp=ffffffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        drain();
        test_streaming();
        drain();
        test_back_pressure();
        drain();
        test_flush_full();
        drain();
        test_async_reset();
        drain();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
        drain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
